// File: rtl/wash_pkg.sv
// Shared state encoding, program-select codes and per-program timing constants
// for the wash sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WASH,
        S_RINSE,
        S_SPIN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_SPIN_ONLY = 2'b00;
    localparam logic [1:0] MODE_SMALL     = 2'b01;
    localparam logic [1:0] MODE_MEDIUM    = 2'b10;
    localparam logic [1:0] MODE_LARGE     = 2'b11;

    localparam logic [3:0] FILL_SMALL   = 4'd3;
    localparam logic [3:0] FILL_MEDIUM  = 4'd4;
    localparam logic [3:0] FILL_LARGE   = 4'd5;
    localparam logic [3:0] WASH_SMALL   = 4'd6;
    localparam logic [3:0] WASH_MEDIUM  = 4'd8;
    localparam logic [3:0] WASH_LARGE   = 4'd10;
    localparam logic [3:0] RINSE_SMALL  = 4'd4;
    localparam logic [3:0] RINSE_MEDIUM = 4'd5;
    localparam logic [3:0] RINSE_LARGE  = 4'd6;
    localparam logic [3:0] SPIN_STD     = 4'd3;
    localparam logic [3:0] SPIN_ONLY    = 4'd5;

    localparam logic [11:0] TOTAL_SPIN_ONLY = 12'h005;
    localparam logic [11:0] TOTAL_SMALL     = 12'h016;
    localparam logic [11:0] TOTAL_MEDIUM    = 12'h020;
    localparam logic [11:0] TOTAL_LARGE     = 12'h024;

    // Seconds spent in a phase for a given program; zero for non-timed states.
    function automatic logic [3:0] phase_dur(input logic [1:0] mode, input state_t ph);
        logic [3:0] d;
        d = 4'd0;
        case (ph)
            S_FILL:  d = (mode == MODE_SMALL) ? FILL_SMALL :
                         (mode == MODE_MEDIUM) ? FILL_MEDIUM : FILL_LARGE;
            S_WASH:  d = (mode == MODE_SMALL) ? WASH_SMALL :
                         (mode == MODE_MEDIUM) ? WASH_MEDIUM : WASH_LARGE;
            S_RINSE: d = (mode == MODE_SMALL) ? RINSE_SMALL :
                         (mode == MODE_MEDIUM) ? RINSE_MEDIUM : RINSE_LARGE;
            S_SPIN:  d = (mode == MODE_SPIN_ONLY) ? SPIN_ONLY : SPIN_STD;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [11:0] total_bcd(input logic [1:0] mode);
        case (mode)
            MODE_SPIN_ONLY: return TOTAL_SPIN_ONLY;
            MODE_SMALL:     return TOTAL_SMALL;
            MODE_MEDIUM:    return TOTAL_MEDIUM;
            default:        return TOTAL_LARGE;
        endcase
    endfunction

    function automatic state_t first_phase(input logic [1:0] mode);
        return (mode == MODE_SPIN_ONLY) ? S_SPIN : S_FILL;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second tick generator: counts enabled cycles and pulses tick on the last
// cycle of every TICK_DIV, holding its count while en is low.
module sec_tick #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washer program sequencer: FILL/WASH/RINSE/SPIN timing, BCD countdown and lid interlock.
// Define WASH_PAUSE_EN to enable the pause/HOLD feature; otherwise pause is ignored.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        door_open,
    input  logic        pause,
    input  logic        ack,
    output logic [4:0]  phase_light,
    output logic [11:0] remain_bcd,
    output logic        busy,
    output logic        done,
    output logic        buzzer_en
);

    state_t     state;
    state_t     run_nxt;
    logic [1:0] mode_q;
    logic [3:0] phase_left;
    logic [3:0] left_nxt;
    logic       running;
    logic       tick_en;
    logic       tick_clr;
    logic       tick;

`ifdef WASH_PAUSE_EN
    state_t     saved_phase;
`else
    logic       pause_unused;
    assign pause_unused = pause;
`endif

    assign running  = (state == S_FILL) || (state == S_WASH) ||
                      (state == S_RINSE) || (state == S_SPIN);
    assign tick_en  = running && !door_open;
    assign tick_clr = !on || (state == S_IDLE);

    sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] light_of(input state_t s);
        case (s)
            S_FILL:  return 5'b00001;
            S_WASH:  return 5'b00010;
            S_RINSE: return 5'b00100;
            S_SPIN:  return 5'b01000;
            S_DONE:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            S_FILL:  return S_WASH;
            S_WASH:  return S_RINSE;
            S_RINSE: return S_SPIN;
            default: return S_DONE;
        endcase
    endfunction

    // The tick that empties a phase also moves to the next one and reloads its length.
    always_comb begin
        run_nxt  = state;
        left_nxt = phase_left;
        if (tick) begin
            if (phase_left <= 4'd1) begin
                run_nxt  = next_phase(state);
                left_nxt = phase_dur(mode_q, run_nxt);
            end else begin
                left_nxt = phase_left - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mode_q      <= 2'b00;
            phase_left  <= 4'd0;
            remain_bcd  <= 12'h000;
            phase_light <= 5'b00000;
            busy        <= 1'b0;
            done        <= 1'b0;
            buzzer_en   <= 1'b0;
`ifdef WASH_PAUSE_EN
            saved_phase <= S_IDLE;
`endif
        end else begin
            done <= 1'b0;
            if (!on) begin
                state       <= S_IDLE;
                mode_q      <= 2'b00;
                phase_left  <= 4'd0;
                remain_bcd  <= 12'h000;
                phase_light <= 5'b00000;
                busy        <= 1'b0;
                buzzer_en   <= 1'b0;
`ifdef WASH_PAUSE_EN
                saved_phase <= S_IDLE;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mode_q      <= mode;
                            state       <= first_phase(mode);
                            phase_left  <= phase_dur(mode, first_phase(mode));
                            remain_bcd  <= total_bcd(mode);
                            phase_light <= light_of(first_phase(mode));
                            busy        <= 1'b1;
                        end
                    end
                    S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                        phase_left  <= left_nxt;
                        if (tick) remain_bcd <= bcd_dec(remain_bcd);
                        phase_light <= light_of(run_nxt);
                        busy        <= (run_nxt != S_DONE);
                        buzzer_en   <= (run_nxt == S_DONE);
                        done        <= (run_nxt == S_DONE);
`ifdef WASH_PAUSE_EN
                        // A pause on the last tick of the program is dropped in favour of DONE.
                        if (pause && run_nxt != S_DONE) begin
                            state       <= S_HOLD;
                            saved_phase <= run_nxt;
                        end else begin
                            state <= run_nxt;
                        end
`else
                        state <= run_nxt;
`endif
                    end
`ifdef WASH_PAUSE_EN
                    S_HOLD: begin
                        if (pause) state <= saved_phase;
                    end
`endif
                    S_DONE: begin
                        if (ack) begin
                            state       <= S_IDLE;
                            phase_light <= 5'b00000;
                            busy        <= 1'b0;
                            buzzer_en   <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with a 4-cycle tick; expectations come from
// program durations and counted running cycles. Honours WASH_PAUSE_EN when defined.
module tb_wash_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, on, start, door_open, pause, ack;
    logic [1:0]  mode;
    logic [4:0]  phase_light;
    logic [11:0] remain_bcd;
    logic        busy, done, buzzer_en;

    int total_n = 0;
    int bad_n   = 0;

    wash_sequencer #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .start       (start),
        .mode        (mode),
        .door_open   (door_open),
        .pause       (pause),
        .ack         (ack),
        .phase_light (phase_light),
        .remain_bcd  (remain_bcd),
        .busy        (busy),
        .done        (done),
        .buzzer_en   (buzzer_en)
    );

    always #5 clk = ~clk;

    // Phase lengths in seconds: ph 0 fill, 1 wash, 2 rinse, 3 spin.
    function automatic int dur(int m, int ph);
        if (m == 0) return (ph == 3) ? 5 : 0;
        case (ph)
            0:       return 2 + m;
            1:       return 4 + 2 * m;
            2:       return 3 + m;
            default: return 3;
        endcase
    endfunction

    function automatic int prog_total(int m);
        int s = 0;
        for (int p = 0; p < 4; p++) s += dur(m, p);
        return s;
    endfunction

    function automatic logic [4:0] exp_light(int m, int secs);
        int bound = 0;
        for (int p = 0; p < 4; p++) begin
            bound += dur(m, p);
            if (secs < bound) return 5'(1 << p);
        end
        return 5'b10000;
    endfunction

    function automatic logic [11:0] to_bcd(int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'($urandom);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Returns the cycle index at which done is seen, or -1 if it never comes.
    task automatic run_to_done(input int from, output int at);
        at = -1;
        for (int i = from; i < from + 400; i++) begin
            if (done === 1'b1) begin
                at = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; on = 1'b1; start = 1'b0; mode = 2'b00;
        door_open = 1'b0; pause = 1'b0; ack = 1'b0;
        repeat (3) step();
        total_n++;
        if ({phase_light, remain_bcd, busy, done, buzzer_en} !== 20'h0) begin
            bad_n++;
            $display("FAIL reset_outputs got=%b/%h/%b%b%b want=0", phase_light, remain_bcd, busy, done, buzzer_en);
        end
        rst = 1'b1;
        step();
        total_n++;
        if ({phase_light, busy, buzzer_en} !== 7'b0) begin
            bad_n++;
            $display("FAIL reset_release got=%b/%b/%b want=idle", phase_light, busy, buzzer_en);
        end
    endtask

    task automatic test_mode01_timing();
        int done_cnt = 0;
        start_prog(2'b01);
        for (int i = 1; i <= 65; i++) begin
            logic [4:0] el;
            el = (i < 13) ? 5'b00001 : (i < 37) ? 5'b00010 : (i < 53) ? 5'b00100 :
                 (i < 65) ? 5'b01000 : 5'b10000;
            total_n++;
            if (phase_light !== el) begin
                bad_n++;
                $display("FAIL m01_light cyc=%0d got=%b want=%b", i, phase_light, el);
            end
            total_n++;
            if (remain_bcd !== to_bcd(16 - (i - 1) / 4)) begin
                bad_n++;
                $display("FAIL m01_remain cyc=%0d got=%h want=%h", i, remain_bcd, to_bcd(16 - (i - 1) / 4));
            end
            if (done === 1'b1) done_cnt++;
            if (i < 65) step();
        end
        total_n++;
        if ({done, buzzer_en, busy} !== 3'b110) begin
            bad_n++;
            $display("FAIL m01_done_entry got=%b%b%b want=110", done, buzzer_en, busy);
        end
        repeat (3) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        total_n++;
        if (done_cnt != 1) begin
            bad_n++;
            $display("FAIL m01_done_pulses got=%0d want=1", done_cnt);
        end
        pulse_ack();
    endtask

    task automatic test_bcd_borrow();
        int at;
        start_prog(2'b10);
        total_n++;
        if (remain_bcd !== 12'h020) begin
            bad_n++;
            $display("FAIL borrow_load got=%h want=020", remain_bcd);
        end
        pulse_ack();
        total_n++;
        if ({busy, phase_light} !== 6'b1_00001) begin
            bad_n++;
            $display("FAIL ack_ignored got=%b/%b want=1/00001", busy, phase_light);
        end
        repeat (3) step();
        total_n++;
        if (remain_bcd !== 12'h019) begin
            bad_n++;
            $display("FAIL borrow_step got=%h want=019", remain_bcd);
        end
        run_to_done(5, at);
        total_n++;
        if (at != 81) begin
            bad_n++;
            $display("FAIL m10_done_cycle got=%0d want=81", at);
        end
        pulse_ack();
        total_n++;
        if ({phase_light, busy, buzzer_en} !== 7'b0) begin
            bad_n++;
            $display("FAIL ack_to_idle got=%b/%b/%b want=0", phase_light, busy, buzzer_en);
        end
    endtask

    task automatic test_spin_only();
        start_prog(2'b00);
        for (int i = 1; i <= 20; i++) begin
            total_n++;
            if ({phase_light, remain_bcd} !== {5'b01000, to_bcd(5 - (i - 1) / 4)}) begin
                bad_n++;
                $display("FAIL spin_only cyc=%0d got=%b/%h want=01000/%h", i, phase_light, remain_bcd, to_bcd(5 - (i - 1) / 4));
            end
            step();
        end
        total_n++;
        if ({phase_light, remain_bcd, done} !== {5'b10000, 12'h000, 1'b1}) begin
            bad_n++;
            $display("FAIL spin_only_done got=%b/%h/%b want=10000/000/1", phase_light, remain_bcd, done);
        end
        pulse_ack();
    endtask

    task automatic test_door();
        int at;
        start_prog(2'b01);
        repeat (19) step();
        for (int i = 20; i < 30; i++) begin
            door_open = 1'b1;
            total_n++;
            if ({phase_light, remain_bcd} !== {5'b00010, 12'h012}) begin
                bad_n++;
                $display("FAIL door_hold cyc=%0d got=%b/%h want=00010/012", i, phase_light, remain_bcd);
            end
            step();
        end
        door_open = 1'b0;
        total_n++;
        if (phase_light !== 5'b00010) begin
            bad_n++;
            $display("FAIL door_light_after got=%b want=00010", phase_light);
        end
        run_to_done(30, at);
        total_n++;
        if (at != 75) begin
            bad_n++;
            $display("FAIL door_done_cycle got=%0d want=75", at);
        end
        pulse_ack();
    endtask

    task automatic test_pause();
        int at;
        logic [11:0] exp_rem;
        start_prog(2'b01);
        repeat (39) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        repeat (5) step();
`ifdef WASH_PAUSE_EN
        exp_rem = 12'h006;
`else
        exp_rem = 12'h005;
`endif
        total_n++;
        if ({busy, phase_light, remain_bcd} !== {1'b1, 5'b00100, exp_rem}) begin
            bad_n++;
            $display("FAIL pause_hold got=%b/%b/%h want=1/00100/%h", busy, phase_light, remain_bcd, exp_rem);
        end
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        run_to_done(48, at);
        total_n++;
`ifdef WASH_PAUSE_EN
        if (at != 72) begin
            bad_n++;
            $display("FAIL pause_done_cycle got=%0d want=72", at);
        end
`else
        if (at != 65) begin
            bad_n++;
            $display("FAIL pause_done_cycle got=%0d want=65", at);
        end
`endif
        pulse_ack();
    endtask

    task automatic test_spurious_start();
        int at;
        start_prog(2'b01);
        repeat (19) step();
        mode  = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        total_n++;
        if ({phase_light, remain_bcd} !== {5'b00010, 12'h011}) begin
            bad_n++;
            $display("FAIL start_in_wash got=%b/%h want=00010/011", phase_light, remain_bcd);
        end
        run_to_done(21, at);
        total_n++;
        if (at != 65) begin
            bad_n++;
            $display("FAIL start_in_wash_done got=%0d want=65", at);
        end
        pulse_ack();
    endtask

    task automatic test_power_abort();
        int done_cnt = 0;
        start_prog(2'b01);
        repeat (57) step();
        total_n++;
        if ({phase_light, remain_bcd} !== {5'b01000, 12'h002}) begin
            bad_n++;
            $display("FAIL pwr_pre got=%b/%h want=01000/002", phase_light, remain_bcd);
        end
        on = 1'b0;
        step();
        total_n++;
        if ({phase_light, remain_bcd, busy, done, buzzer_en} !== 20'h0) begin
            bad_n++;
            $display("FAIL pwr_off got=%b/%h/%b%b%b want=0", phase_light, remain_bcd, busy, done, buzzer_en);
        end
        start_prog(2'b01);
        total_n++;
        if ({busy, remain_bcd} !== 13'h0) begin
            bad_n++;
            $display("FAIL pwr_off_start got=%b/%h want=0/000", busy, remain_bcd);
        end
        on = 1'b1;
        repeat (40) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        total_n++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad_n++;
            $display("FAIL pwr_no_resume got=%0d/%b want=0/0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        start_prog(2'b11);
        repeat (29) step();
        total_n++;
        if ({busy, phase_light} !== 6'b1_00010) begin
            bad_n++;
            $display("FAIL rst_pre got=%b/%b want=1/00010", busy, phase_light);
        end
        #2;
        rst = 1'b0;
        #1;
        total_n++;
        if ({phase_light, remain_bcd, busy, done, buzzer_en} !== 20'h0) begin
            bad_n++;
            $display("FAIL rst_async got=%b/%h/%b%b%b want=0", phase_light, remain_bcd, busy, done, buzzer_en);
        end
        step();
        rst = 1'b1;
        repeat (150) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        total_n++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad_n++;
            $display("FAIL rst_no_done got=%0d/%b want=0/0", done_cnt, busy);
        end
    endtask

    // Random programs with random lid openings, stray start/ack/pause pulses, and
    // random program changes; every cycle is compared against the seconds model.
    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int m, tot, active, secs, guard;
            bit paused, fin;
            m = $urandom_range(0, 3);
            tot = prog_total(m);
            active = 0; guard = 0; paused = 1'b0; fin = 1'b0;
            start_prog(2'(m));
            while (!fin && guard < 2000) begin
                secs = active / TD;
                total_n++;
                if ({phase_light, remain_bcd, busy, done, buzzer_en} !==
                    {exp_light(m, secs), to_bcd(tot - secs), secs < tot, secs >= tot, secs >= tot}) begin
                    bad_n++;
                    $display("FAIL rand r=%0d m=%0d cyc=%0d got=%b/%h/%b%b%b want=%b/%h/%b%b%b", r, m, guard,
                             phase_light, remain_bcd, busy, done, buzzer_en,
                             exp_light(m, secs), to_bcd(tot - secs), secs < tot, secs >= tot, secs >= tot);
                end
                if (secs >= tot) begin
                    fin = 1'b1;
                end else begin
                    door_open = ($urandom_range(0, 5) == 0);
                    start     = ($urandom_range(0, 19) == 0);
                    ack       = ($urandom_range(0, 19) == 0);
                    pause     = ($urandom_range(0, 29) == 0);
                    mode      = 2'($urandom);
                    if (!paused && !door_open) active++;
`ifdef WASH_PAUSE_EN
                    if (pause) begin
                        if (paused) paused = 1'b0;
                        else if (active / TD < tot) paused = 1'b1;
                    end
`endif
                    step();
                    guard++;
                end
            end
            start = 1'b0; ack = 1'b0; pause = 1'b0; door_open = 1'b0;
            total_n++;
            if (!fin) begin
                bad_n++;
                $display("FAIL rand_timeout r=%0d got=running want=done", r);
            end
            pulse_ack();
            total_n++;
            if ({phase_light, busy, buzzer_en} !== 7'b0) begin
                bad_n++;
                $display("FAIL rand_ack r=%0d got=%b/%b/%b want=0", r, phase_light, busy, buzzer_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode01_timing();
        test_bcd_borrow();
        test_spin_only();
        test_door();
        test_pause();
        test_spurious_start();
        test_power_abort();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, gives the clk cycles per 1 s tick (100 MHz board clock).
REQ-002 Port clk, input, 1 bit, the single system clock; all state SHALL be on its rising edge.
REQ-003 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 Port on, input, 1 bit, power enable.
REQ-005 Port start, input, 1 bit, one-cycle pulse from billing `next` meaning payment is confirmed.
REQ-006 Port mode, input, 2 bits, program select: 00 spin-only, 01 small, 10 medium, 11 large.
REQ-007 Port door_open, input, 1 bit, level input from the lid switch.
REQ-008 Port pause, input, 1 bit, one-cycle pulse from an already-debounced button.
REQ-009 Port ack, input, 1 bit, one-cycle pulse meaning the clothes are collected.
REQ-010 Port phase_light, output, 5 bits, one-hot {done, spin, rinse, wash, fill}.
REQ-011 Port remain_bcd, output, 12 bits, 3-digit BCD of total seconds remaining.
REQ-012 Port busy, output, 1 bit, high in any running or paused state.
REQ-013 Port done, output, 1 bit, one-cycle pulse on entry to DONE.
REQ-014 Port buzzer_en, output, 1 bit, high while in DONE.

Function
REQ-015 The states SHALL be IDLE, FILL, WASH, RINSE, SPIN, HOLD and DONE.
REQ-016 Phase durations SHALL be:
- FILL 3/4/5 s for small/medium/large.
- WASH 6/8/10 s.
- RINSE 4/5/6 s.
- SPIN 3 s for small/medium/large.
- Mode 00 runs SPIN only, for 5 s.
REQ-017 In IDLE with on=1, a start pulse SHALL latch mode and load remain_bcd with the program total:
- 005 for mode 00, 016 for 01, 020 for 10, 024 for 11.
- The load is visible the next cycle.
- The first phase and the tick counter SHALL be loaded and cleared in the same edge.
REQ-018 start SHALL be ignored outside IDLE; mode changes after the latch SHALL be ignored.
REQ-019 The tick counter SHALL advance only in FILL/WASH/RINSE/SPIN with door_open=0, and issue a tick on count TICK_DIV-1, then wrap to 0.
REQ-020 On each tick:
- phase_left and remain_bcd SHALL decrement by 1.
- BCD borrow rule: a digit of 0 becomes 9 and borrows from the next digit.
REQ-021 When a tick takes phase_left to 0, that same edge SHALL enter the next phase (FILL→WASH→RINSE→SPIN→DONE) and load its duration.
REQ-022 remain_bcd SHALL reach 000 exactly on the edge entering DONE.
REQ-023 With door_open=1 in a running phase, the tick counter SHALL freeze and phase_light SHALL stay on the current phase; it resumes with no lost or extra cycles when the door closes.
REQ-024 In DONE:
- done SHALL pulse for exactly one cycle on entry.
- buzzer_en SHALL be 1.
- An ack pulse SHALL return the block to IDLE; ack in any other state SHALL be ignored.
REQ-025 on=0 SHALL synchronously force IDLE and clear remain_bcd, the counters and all outputs within one cycle; on has priority over every other input.
REQ-026 phase_light SHALL be 00000 in IDLE, one-hot per phase while running or in HOLD, and 10000 in DONE.

Reset
REQ-027 rst=0 SHALL asynchronously set:
- state to IDLE.
- remain_bcd to 000.
- phase_light to 0, busy to 0, done to 0, buzzer_en to 0.
- tick counter, phase_left and the latched mode to 0.
REQ-028 Reset asserted mid-cycle SHALL abort the program; no done pulse SHALL follow the release.

Configuration
REQ-029 The pause feature SHALL be controlled by macro WASH_PAUSE_EN.
REQ-030 When WASH_PAUSE_EN is defined:
- A pause pulse in FILL/WASH/RINSE/SPIN SHALL enter HOLD and save the phase.
- A pause pulse in HOLD SHALL resume the saved phase with phase_left and the tick counter unchanged.
- In HOLD, busy SHALL be 1 and the timer frozen.
REQ-031 When WASH_PAUSE_EN is undefined, the pause port SHALL exist but be ignored, and HOLD SHALL be unreachable.

Structure
REQ-032 The shared package wash_pkg SHALL hold:
- the state enum.
- the mode encodings.
- the per-mode phase-duration constants.
- the per-mode total-time BCD constants.
REQ-033 The 1 s tick generator SHALL be a sub-module sec_tick, with ports clk, rst, en, clr and tick.

Verification (TICK_DIV=4)
REQ-034 Mode 01 start, door closed:
- Expect FILL, WASH, RINSE, SPIN entered at cycles 1, 13, 37, 53 after start.
- Expect DONE at cycle 65.
- Expect remain_bcd to step 016→015…→000.
- Expect a single done pulse.
REQ-035 remain_bcd 020 plus one tick SHALL give 019 (BCD borrow check); then ack in DONE returns to IDLE with buzzer_en=0.
REQ-036 Door interlock: door_open=1 for 10 cycles during WASH SHALL delay DONE by exactly 10 cycles, and phase_light SHALL stay 00010 throughout.
REQ-037 With WASH_PAUSE_EN defined:
- pause in RINSE, then a second pause 7 cycles later, SHALL delay DONE by 7 cycles.
- Undefined: pause has no effect on timing.
REQ-038 Power and reset abort:
- on=0 during SPIN with remain_bcd 002 gives IDLE and 000 next cycle.
- Asserting rst mid-WASH clears all outputs immediately.
REQ-039 Ignored inputs:
- start pulses during WASH SHALL be ignored.
- Mode 00 SHALL run SPIN only, 5 ticks, lights 01000 then 10000.
